// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: parses 'W'/'R' commands from a received byte stream and
// issues single-word transactions on the SoC mem_* bus, answering over the UART.
module uart_bus_master #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TIMEOUT  = CLK_FREQ / 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy,
  output logic        bus_req,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h4B;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, RD, RD_WAIT, RESP} state_t;

  // Latched command; the address is kept word-aligned by never storing [1:0].
  typedef struct packed {
    logic        is_wr;
    logic [31:2] addr;
    logic [31:0] wdata;
  } cmd_t;

  state_t      state_q, state_d;
  cmd_t        cmd_q;
  logic [1:0]  cnt_q;
  logic [TW-1:0] tmo_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic is_op, tmo_fire, field_done, resp_last, busy_state;

  assign is_op      = (rx_data == OP_WR) || (rx_data == OP_RD);
  assign tmo_fire   = ((state_q == ADDR) || (state_q == DATA)) && (tmo_q == TW'(TIMEOUT));
  assign field_done = rx_valid && (cnt_q == 2'd3);
  assign resp_last  = cmd_q.is_wr || (cnt_q == 2'd3);
  assign busy_state = state_q inside {WR, RD, RD_WAIT, RESP};

  assign bus_req   = (state_q != IDLE);
  assign mem_addr  = {cmd_q.addr, 2'b00};
  assign mem_wdata = cmd_q.wdata;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b0;
    unique case (state_q)
      IDLE: if (rx_valid && is_op) state_d = ADDR;
      ADDR: begin
        // A timeout on the same cycle as a byte wins; the byte is lost.
        if (tmo_fire)        state_d = IDLE;
        else if (field_done) state_d = cmd_q.is_wr ? DATA : RD;
      end
      DATA: begin
        if (tmo_fire)        state_d = IDLE;
        else if (field_done) state_d = WR;
      end
      WR: begin
        mem_wmask = 4'hF;
        if (!mem_wbusy) state_d = RESP;
      end
      RD: begin
        mem_rstrb = 1'b1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: if (!mem_rbusy) state_d = RESP;
      RESP: begin
        tx_valid = 1'b1;
        tx_data  = cmd_q.is_wr ? ACK : rdata_q[{cnt_q, 3'b000} +: 8];
        if (tx_ready && resp_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      tmo_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (rx_valid) begin
            if (is_op) begin
              cmd_q.is_wr <= (rx_data == OP_WR);
              cnt_q       <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ADDR, DATA: begin
          if (tmo_fire) begin
            err_q <= 1'b1;
            cnt_q <= '0;
          end else if (rx_valid) begin
            cnt_q <= cnt_q + 2'd1;
            if (state_q == ADDR) begin
              unique case (cnt_q)
                2'd0: cmd_q.addr[7:2]   <= rx_data[7:2];
                2'd1: cmd_q.addr[15:8]  <= rx_data;
                2'd2: cmd_q.addr[23:16] <= rx_data;
                2'd3: cmd_q.addr[31:24] <= rx_data;
              endcase
            end else begin
              cmd_q.wdata[{cnt_q, 3'b000} +: 8] <= rx_data;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RD_WAIT: if (!mem_rbusy) rdata_q <= mem_rdata;
        RESP: if (tx_ready) cnt_q <= resp_last ? 2'd0 : cnt_q + 2'd1;
        default: ;
      endcase
      // Bytes arriving while a bus cycle or response is in flight are dropped.
      if (rx_valid && busy_state) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized bench for uart_bus_master: a command-level model predicts bus
// transactions, response bytes, err pulses and latency for each command.
module tb_uart_bus_master;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rbusy = 1'b0;
  logic        mem_wbusy = 1'b0;
  logic        bus_req, err;

  uart_bus_master #(.CLK_FREQ(25_000_000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
    .mem_wbusy(mem_wbusy), .bus_req(bus_req), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Environment data for never-written words, shared by bus model and reference.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [7:0]  cmd[$], got_tx[$], exp_tx[$];

  int  err_cnt, wmask_cycles, rstrb_cycles, n_wr, n_rd;
  int  first_tx, last_rx, req_fall;
  int  cfg_wst = 0, cfg_rst = 0, wleft = 0, rleft = 0, hold = 0;
  bit  saw_req, bp_mode = 1'b0, prev_req, hold_pend, rd_pend;
  logic [7:0]  hold_data;
  logic [31:0] rd_addr, got_wa, got_wd, got_ra;

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  // Bus slave, UART transmitter and observation, all on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      mem_wbusy = 1'b0; mem_rbusy = 1'b0; rd_pend = 1'b0;
      wleft = cfg_wst; hold = 0; hold_pend = 1'b0; prev_req = 1'b0;
      tx_ready = !bp_mode;
    end else begin
      if (hold_pend)
        chk("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, hold_data}));
      if (mem_wmask == 4'hF) begin
        wmask_cycles++;
        if (wleft > 0) begin
          mem_wbusy = 1'b1; wleft--;
        end else begin
          mem_wbusy = 1'b0; n_wr++; got_wa = mem_addr; got_wd = mem_wdata;
          bus_mem[mem_addr] = mem_wdata; wleft = cfg_wst;
        end
      end else begin
        mem_wbusy = 1'b0;
      end
      if (rd_pend) begin
        if (rleft > 0) begin
          mem_rbusy = 1'b1; rleft--; mem_rdata = ~bus_rd(rd_addr);
        end else begin
          mem_rbusy = 1'b0; mem_rdata = bus_rd(rd_addr); rd_pend = 1'b0;
        end
      end else begin
        mem_rbusy = 1'b0; mem_rdata = $urandom;
      end
      if (mem_rstrb) begin
        rstrb_cycles++; n_rd++; got_ra = mem_addr; rd_addr = mem_addr;
        rd_pend = 1'b1; rleft = cfg_rst; mem_rbusy = 1'b1;
      end
      if (!bp_mode)            tx_ready = 1'b1;
      else if (!tx_valid)      tx_ready = 1'b0;
      else if (hold == 5)      begin tx_ready = 1'b1; hold = 0; end
      else                     begin tx_ready = 1'b0; hold++; end
      if (tx_valid && first_tx < 0) first_tx = cyc;
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (err) err_cnt++;
      if (rx_valid) last_rx = cyc;
      if (bus_req) saw_req = 1'b1;
      if (prev_req && !bus_req) req_fall = cyc;
      prev_req = bus_req;
    end
  end

  // Reference: what one command should do on the bus and the UART.
  bit exp_w, exp_r, exp_own;
  int exp_err, cmd_len;
  logic [31:0] exp_a, exp_d;

  task automatic model_cmd();
    int need;
    logic [31:0] d;
    exp_tx.delete(); exp_w = 0; exp_r = 0; exp_own = 1;
    need = (cmd[0] == 8'h57) ? 9 : (cmd[0] == 8'h52) ? 5 : 1;
    cmd_len = (cmd.size() < need) ? cmd.size() : need;
    if (need == 1) begin
      exp_own = 0; exp_err = cmd.size();
    end else if (cmd.size() < need) begin
      exp_err = 1;
    end else begin
      exp_err = cmd.size() - need;
      exp_a = {cmd[4], cmd[3], cmd[2], cmd[1]} & 32'hFFFF_FFFC;
      if (need == 9) begin
        exp_w = 1; exp_d = {cmd[8], cmd[7], cmd[6], cmd[5]};
        ref_mem[exp_a] = exp_d;
        exp_tx.push_back(8'h4B);
      end else begin
        exp_r = 1;
        d = ref_mem.exists(exp_a) ? ref_mem[exp_a] : init_word(exp_a);
        for (int b = 0; b < 4; b++) exp_tx.push_back(d[8*b +: 8]);
      end
    end
  endtask

  task automatic cmd_w(input logic [31:0] a, input logic [31:0] d);
    cmd.delete(); cmd.push_back(8'h57);
    for (int b = 0; b < 4; b++) cmd.push_back(a[8*b +: 8]);
    for (int b = 0; b < 4; b++) cmd.push_back(d[8*b +: 8]);
  endtask

  task automatic cmd_r(input logic [31:0] a);
    cmd.delete(); cmd.push_back(8'h52);
    for (int b = 0; b < 4; b++) cmd.push_back(a[8*b +: 8]);
  endtask

  // Called in the posedge+1 phase; returns in the same phase.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic clear_obs(input int wst, input int rs, input bit bp);
    cfg_wst = wst; cfg_rst = rs; wleft = wst; bp_mode = bp;
    got_tx.delete(); err_cnt = 0; wmask_cycles = 0; rstrb_cycles = 0;
    n_wr = 0; n_rd = 0; first_tx = -1; saw_req = 0; req_fall = -1;
  endtask

  task automatic run_cmd(input int glo, input int ghi, input int wst, input int rs, input bit bp);
    int k, lat_base;
    model_cmd();
    clear_obs(wst, rs, bp);
    lat_base = 0;
    for (int i = 0; i < cmd.size(); i++) begin
      send_byte(cmd[i]);
      if (i == cmd_len - 1) lat_base = last_rx;
      if (i < cmd_len - 1) repeat ($urandom_range(ghi, glo)) begin @(posedge clk); #1; end
    end
    k = 0;
    if (exp_own) begin
      while (!(saw_req && !bus_req) && k < 2000) begin @(posedge clk); #1; k++; end
      chk("cmd_done", 32'(k < 2000), 32'd1);
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("own", 32'(saw_req), 32'(exp_own));
    chk("tx_count", got_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      chk($sformatf("tx_byte%0d", i), 32'(got_tx[i]), 32'(exp_tx[i]));
    chk("wr_count", n_wr, 32'(exp_w));
    if (exp_w) begin
      chk("wr_addr", got_wa, exp_a);
      chk("wr_data", got_wd, exp_d);
    end
    chk("wmask_cycles", wmask_cycles, exp_w ? 1 + wst : 0);
    chk("rd_count", n_rd, 32'(exp_r));
    if (exp_r) chk("rd_addr", got_ra, exp_a);
    chk("rstrb_cycles", rstrb_cycles, 32'(exp_r));
    chk("err_pulses", err_cnt, exp_err);
    if (exp_w || exp_r) chk("latency", first_tx - lat_base, exp_w ? 2 + wst : 3 + rs);
    if (exp_own && !exp_w && !exp_r)
      chk("tmo_window", 32'((req_fall - last_rx >= TMO - 1) && (req_fall - last_rx <= TMO + 3)), 32'd1);
    chk("idle_after", 32'({tx_valid, bus_req}), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] addrs[4];
    logic [7:0] b;
    addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h100; addrs[3] = 32'h2000_0004;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'({tx_valid, tx_data}), 32'd0);
    chk("rst_bus", 32'({mem_wmask, mem_rstrb, bus_req, err}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    cmd_w(32'h10, 32'hDEAD_BEEF);  run_cmd(0, 0, 0, 0, 0);
    cmd_r(32'h10);                 run_cmd(0, 0, 0, 0, 0);
    cmd_w(32'h20, $urandom);       run_cmd(0, 1, 3, 0, 0);
    cmd_r(32'h20);                 run_cmd(0, 1, 0, 2, 0);
    cmd_r(32'h10);                 run_cmd(0, 0, 0, 0, 1);
    cmd.delete(); cmd.push_back(8'h41); run_cmd(0, 0, 0, 0, 0);
    cmd.delete(); cmd.push_back(8'h57); cmd.push_back(8'h01); cmd.push_back(8'h02);
    run_cmd(0, 0, 0, 0, 0);
    cmd_r(32'h14);                 run_cmd(0, 0, 0, 0, 0);
    cmd_r(32'h13);                 run_cmd(0, 0, 0, 0, 0);
    cmd_w(32'h24, $urandom);       run_cmd(TMO - 3, TMO - 3, 0, 0, 0);
    cmd_r(32'h24); cmd.push_back(8'h52); run_cmd(0, 0, 0, 1, 0);
    cmd_w(32'h28, $urandom); cmd.push_back(8'h00); run_cmd(0, 0, 1, 0, 0);

    // Reset in the middle of a read response
    cmd_r(32'h10); model_cmd(); clear_obs(0, 0, 1);
    for (int i = 0; i < cmd.size(); i++) send_byte(cmd[i]);
    k = 0;
    while (got_tx.size() < 2 && k < 500) begin @(posedge clk); #1; k++; end
    chk("rst_wait", 32'(k < 500), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_tx", 32'({tx_valid, bus_req, mem_rstrb, mem_wmask}), 32'd0);
    chk("rst_mid_cnt", got_tx.size(), 32'd2);
    if (got_tx.size() >= 2) begin
      chk("rst_mid_b0", 32'(got_tx[0]), 32'(exp_tx[0]));
      chk("rst_mid_b1", 32'(got_tx[1]), 32'(exp_tx[1]));
    end
    rst = 1'b0; bp_mode = 1'b0;
    @(posedge clk); #1;
    cmd_r(32'h10);                 run_cmd(0, 0, 0, 0, 0);

    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(9, 0);
      if (k == 0) begin
        b = 8'($urandom_range(255, 0));
        if (b == 8'h57 || b == 8'h52) b = 8'h3C;
        cmd.delete(); cmd.push_back(b);
      end else if (k < 5) begin
        cmd_w(addrs[$urandom_range(3, 0)] | 32'($urandom_range(3, 0)), $urandom);
      end else begin
        cmd_r(addrs[$urandom_range(3, 0)] | 32'($urandom_range(3, 0)));
      end
      if (k != 0 && $urandom_range(4, 0) == 0) cmd.push_back(8'($urandom_range(255, 0)));
      run_cmd(0, 3, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven bus initiator (debug/loader bridge). It takes a decoded byte stream from a UART receiver, parses read and write commands, and issues single-word transactions on the SoC data bus (the same mem_* signal set the CPU drives).
- It returns read data or acknowledge bytes to a UART transmitter.
- It sits beside the CPU. The SoC muxes its mem_* outputs onto the bus while bus_req is high and stalls the CPU for that time.

Parameters:
- CLK_FREQ, 25000000, system clock in Hz; documentation only, used to derive TIMEOUT.
- TIMEOUT, 250000, maximum idle cycles between bytes of one command (10 ms at 25 MHz) before abort.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- tx_data  output  8  byte to transmit
- tx_valid  output  1  byte available; held until accepted
- tx_ready  input  1  transmitter can accept; a byte transfers on a cycle with tx_valid & tx_ready
- mem_addr  output  32  bus address; bits [1:0] always 0
- mem_wdata  output  32  write data
- mem_wmask  output  4  byte write enables (4'hF or 4'h0)
- mem_rstrb  output  1  read strobe
- mem_rdata  input  32  read data
- mem_rbusy  input  1  read not yet complete
- mem_wbusy  input  1  write not yet complete
- bus_req  output  1  module owns the bus; high whenever state != IDLE
- err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset: state = IDLE. All of tx_valid, tx_data, mem_addr, mem_wdata, mem_wmask, mem_rstrb, bus_req and err are 0. Byte counter and timeout counter are 0.
- Protocol: all multi-byte fields are little-endian.
  - Write command: 0x57 ('W'), then addr0..addr3, then data0..data3. Response is one byte, 0x4B ('K').
  - Read command: 0x52 ('R'), then addr0..addr3. Response is data0..data3, LSB first.
- States: IDLE, ADDR, DATA, WR, RD, RD_WAIT, RESP.
- IDLE:
  - rx_valid with 0x57 or 0x52: latch the opcode, clear the byte counter, go to ADDR.
  - Any other byte: pulse err the next cycle and stay in IDLE.
- ADDR:
  - Each rx_valid shifts rx_data into addr[8*cnt +: 8] and increments cnt.
  - On the 4th byte: a write goes to DATA; a read goes to RD.
  - The latched address has bits [1:0] forced to 0 when it is presented on mem_addr.
- DATA: same as ADDR, but into wdata. On the 4th byte go to WR.
- Timeout in ADDR/DATA:
  - The counter clears on every rx_valid and increments otherwise.
  - When it reaches TIMEOUT: pulse err, return to IDLE, issue no bus cycle and send no response.
- WR:
  - mem_addr and mem_wdata are driven and mem_wmask = 4'hF.
  - If mem_wbusy = 1, stay in WR with all signals held.
  - When mem_wbusy = 0 on a cycle, the write completes that cycle. mem_wmask returns to 0 next cycle; go to RESP with tx_data = 0x4B.
- RD:
  - mem_rstrb = 1 for exactly one cycle with mem_addr valid; go to RD_WAIT.
- RD_WAIT:
  - mem_rstrb = 0; mem_addr stays held.
  - Capture mem_rdata on the first cycle with mem_rbusy = 0. With the zero-wait SoC this is the cycle immediately after the strobe.
  - Then go to RESP, with the byte counter at 0.
- RESP:
  - tx_valid = 1 and tx_data = the current byte.
  - On tx_valid & tx_ready, advance to the next byte; tx_valid stays high between consecutive bytes.
  - After the last byte (1 for write, 4 for read), go to IDLE; tx_valid and bus_req are 0 from the next cycle.
- bus_req: asserted from the cycle after the opcode is accepted until the return to IDLE.
- Bytes received outside IDLE/ADDR/DATA (i.e. in WR, RD, RD_WAIT, RESP): dropped, with an err pulse. The state machine is not disturbed.
- rx_valid on the same cycle a timeout fires: the timeout wins and the byte is dropped.
- Reset asserted mid-command or mid-response: immediate return to reset values on the next clock edge. Any partially sent response is abandoned; a pending bus cycle is withdrawn (mem_wmask/mem_rstrb go to 0).
- Latency with zero-wait bus, from the final rx_valid to the first tx_valid:
  - Write: 2 cycles (DATA→WR→RESP).
  - Read: 3 cycles (ADDR→RD→RD_WAIT→RESP).

Test Plan:
- Write: bytes 57 10 00 00 00 EF BE AD DE with tx_ready = 1 → exactly one cycle of mem_wmask = F with mem_addr = 0x00000010 and mem_wdata = 0xDEADBEEF. Then tx byte 0x4B; bus_req low afterwards.
- Read: bytes 52 10 00 00 00, model memory returns 0xDEADBEEF the cycle after mem_rstrb → tx bytes EF, BE, AD, DE in order. mem_rstrb is high exactly one cycle.
- Busy stalls:
  - mem_wbusy held high for 3 cycles → mem_wmask = F for 4 cycles.
  - mem_rbusy high for 2 cycles after the strobe → data captured on the 3rd RD_WAIT cycle.
- Backpressure: read with tx_ready low for 5 cycles per byte → tx_data stable while tx_valid is high; all 4 bytes are sent once each, in order.
- Errors:
  - Opcode 0x41 → one err pulse, no bus activity.
  - 57 01 02, then silence for TIMEOUT cycles → err pulse, back in IDLE; a subsequent valid read command works.
  - Unaligned address 52 13 00 00 00 → mem_addr = 0x00000010.
- Reset mid-response: assert rst after the 2nd read byte is sent → tx_valid = 0 and bus_req = 0 the next cycle; the next command completes normally.
